// File: rtl/keypad_input_if.sv
// Key handshake bundle between keypad_input and the CPU I/O bus.
// master = keypad_input (produces key codes), slave = consumer.
interface keypad_input_if;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_ack;
    logic        overflow;
    logic        value_clr;
    logic [31:0] value;

    modport master (
        output key_code,
        output key_ready,
        output overflow,
        output value,
        input  key_ack,
        input  value_clr
    );

    modport slave (
        input  key_code,
        input  key_ready,
        input  overflow,
        input  value,
        output key_ack,
        output value_clr
    );
endinterface

// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low hex keypad, debounces presses and
// releases, and hands key codes to the core over a ready/ack handshake.
// Optional feature macro KEYPAD_SHIFT_REG_EN: accumulate accepted hex digits
// into a 32-bit value register; when undefined, value is tied to zero.
module keypad_input #(
    parameter int unsigned SCAN_TICKS     = 256,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     rows,
    output logic [3:0]     cols,
    keypad_input_if.master bus
);
    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    cols_q;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rel_cnt;
    logic [3:0]    key_code_q;
    logic          key_ready_q;
    logic          overflow_q;

    logic          sample;
    logic          valid;
    logic [3:0]    row_low;
    logic [1:0]    row_now;
    logic          accept;
    logic [3:0]    accept_code;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_m <= '1;
            rows_s <= '1;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
        end
    end

    // Decode the synchronized rows: a valid sample has exactly one row low
    always_comb begin
        row_low = ~rows_s;
        valid   = (row_low != 4'b0000) && ((row_low & (row_low - 4'd1)) == 4'b0000);
        row_now = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (row_low[i]) begin
                row_now = 2'(i);
            end
        end
        sample      = (tick_cnt == TICK_LAST);
        accept_code = {row_now, col_idx};
        accept      = 1'b0;
        if (sample && valid) begin
            if (state == SCAN && DEBOUNCE_SCANS == 1) begin
                accept = 1'b1;
            end else if (state == DEBOUNCE && row_now == row_idx && deb_cnt == DEB_LAST) begin
                accept = 1'b1;
            end
        end
    end

    // Scan/debounce/hold FSM plus registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            tick_cnt    <= '0;
            cols_q      <= 4'b1110;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_code_q  <= '0;
            key_ready_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tick_cnt <= sample ? '0 : tick_cnt + 1'b1;

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (valid) begin
                            row_idx <= row_now;
                            deb_cnt <= CW'(1);
                            rel_cnt <= '0;
                            state   <= (DEBOUNCE_SCANS == 1) ? HOLD : DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            cols_q  <= {cols_q[2:0], cols_q[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (valid && row_now == row_idx) begin
                            deb_cnt <= deb_cnt + 1'b1;
                            if (deb_cnt == DEB_LAST) begin
                                rel_cnt <= '0;
                                state   <= HOLD;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                            cols_q  <= {cols_q[2:0], cols_q[3]};
                        end
                    end
                    HOLD: begin
                        if (rows_s == 4'b1111) begin
                            if (rel_cnt == DEB_LAST) begin
                                rel_cnt <= '0;
                                state   <= SCAN;
                                col_idx <= col_idx + 2'd1;
                                cols_q  <= {cols_q[2:0], cols_q[3]};
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end

            if (accept) begin
                key_code_q  <= accept_code;
                key_ready_q <= 1'b1;
                if (key_ready_q && !bus.key_ack) begin
                    overflow_q <= 1'b1;
                end
            end else if (bus.key_ack) begin
                key_ready_q <= 1'b0;
                overflow_q  <= 1'b0;
            end
        end
    end

    assign cols          = cols_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_ready = key_ready_q;
    assign bus.overflow  = overflow_q;

`ifdef KEYPAD_SHIFT_REG_EN
    logic [31:0] value_q;

    // Shift accepted digits in at the low nibble; clear discards history
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (bus.value_clr) begin
            value_q <= accept ? {28'h0, accept_code} : '0;
        end else if (accept) begin
            value_q <= {value_q[27:0], accept_code};
        end
    end

    assign bus.value = value_q;
`else
    assign bus.value = '0;
`endif
endmodule

// File: tb/tb_keypad_input.sv
// Self-checking bench for keypad_input (SCAN_TICKS=4, DEBOUNCE_SCANS=2).
// A behavioural keypad drives rows from the pressed-key set and the DUT's
// column drive; a transaction-level model predicts the handshake outputs.
module tb_keypad_input;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        raw_mode;
    logic [3:0]  raw_rows;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    logic        m_ready;
    logic        m_ovf;
    logic [3:0]  m_code;
    logic [31:0] m_value;

    typedef struct {
        logic [3:0]  key;
        logic        ack;
        logic [3:0]  exp_code;
        logic        exp_ovf;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[5];

    keypad_input_if bus();

    keypad_input #(
        .SCAN_TICKS(4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rows(rows),
        .cols(cols),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        rows = 4'b1111;
        if (raw_mode) begin
            rows = raw_rows;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (!cols[c]) begin
                    for (int r = 0; r < 4; r++) begin
                        if (pressed[r*4+c]) rows[r] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_value(input logic [31:0] v);
`ifdef KEYPAD_SHIFT_REG_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        raw_mode      = 1'b0;
        raw_rows      = 4'b1111;
        pressed       = '0;
        bus.key_ack   = 1'b0;
        bus.value_clr = 1'b0;
        step(2);
        rst     = 1'b0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_code  = 4'h0;
        m_value = 32'h0;
    endtask

    task automatic ack_pulse();
        bus.key_ack = 1'b1;
        step(1);
        bus.key_ack = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] k);
        pressed    = '0;
        pressed[k] = 1'b1;
        step(60);
        pressed = '0;
        step(60);
    endtask

    task automatic wait_ready(input string name, input int limit);
        for (int i = 0; i < limit && !bus.key_ready; i++) step(1);
        check(name, {31'h0, bus.key_ready}, 32'h1);
    endtask

    task automatic model_accept(input logic [3:0] k);
        if (m_ready) m_ovf = 1'b1;
        m_ready = 1'b1;
        m_code  = k;
        m_value = {m_value[27:0], k};
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_ready"}, {31'h0, bus.key_ready}, {31'h0, m_ready});
        check({tag, "_code"},  {28'h0, bus.key_code},  {28'h0, m_code});
        check({tag, "_ovf"},   {31'h0, bus.overflow},  {31'h0, m_ovf});
        check({tag, "_value"}, bus.value, exp_value(m_value));
    endtask

    initial begin
        logic [3:0]  e;
        logic [3:0]  last_cols;
        int          changes;
        logic [3:0]  k;
        logic        a;

        vecs[0] = '{key: 4'h6, ack: 1'b1, exp_code: 4'h6, exp_ovf: 1'b0, exp_val: 32'h00000006};
        vecs[1] = '{key: 4'h1, ack: 1'b0, exp_code: 4'h1, exp_ovf: 1'b0, exp_val: 32'h00000061};
        vecs[2] = '{key: 4'h2, ack: 1'b1, exp_code: 4'h2, exp_ovf: 1'b1, exp_val: 32'h00000612};
        vecs[3] = '{key: 4'hF, ack: 1'b0, exp_code: 4'hF, exp_ovf: 1'b0, exp_val: 32'h0000612F};
        vecs[4] = '{key: 4'h0, ack: 1'b1, exp_code: 4'h0, exp_ovf: 1'b1, exp_val: 32'h000612F0};

        // Reset state and idle column rotation
        do_reset();
        check("rst_cols",  {28'h0, cols}, 32'he);
        check("rst_ready", {31'h0, bus.key_ready}, 32'h0);
        check("rst_code",  {28'h0, bus.key_code}, 32'h0);
        check("rst_ovf",   {31'h0, bus.overflow}, 32'h0);
        check("rst_value", bus.value, 32'h0);
        for (int n = 1; n <= 16; n++) begin
            step(1);
            e = 4'b0001 << ((n / 4) % 4);
            e = ~e;
            check("rotate_cols", {28'h0, cols}, {28'h0, e});
        end

        // Exact latency, release timing, and ack coinciding with accept
        do_reset();
        raw_mode = 1'b1;
        raw_rows = 4'b1110;
        step(7);
        check("latency_before", {31'h0, bus.key_ready}, 32'h0);
        step(1);
        check("latency_ready", {31'h0, bus.key_ready}, 32'h1);
        check("latency_code",  {28'h0, bus.key_code}, 32'h0);
        raw_rows = 4'b1111;
        step(7);
        check("hold_cols", {28'h0, cols}, 32'he);
        step(1);
        check("release_cols", {28'h0, cols}, 32'hd);
        raw_rows = 4'b1110;
        step(7);
        check("ackacc_pre_code", {28'h0, bus.key_code}, 32'h0);
        bus.key_ack = 1'b1;
        step(1);
        bus.key_ack = 1'b0;
        check("ackacc_ready", {31'h0, bus.key_ready}, 32'h1);
        check("ackacc_code",  {28'h0, bus.key_code}, 32'h1);
        check("ackacc_ovf",   {31'h0, bus.overflow}, 32'h0);
        raw_rows = 4'b1111;
        step(20);
        ack_pulse();
        check("ackacc_cleared", {31'h0, bus.key_ready}, 32'h0);

        // Reset while debouncing
        do_reset();
        raw_mode = 1'b1;
        raw_rows = 4'b1110;
        step(5);
        rst      = 1'b1;
        raw_rows = 4'b1111;
        step(1);
        check("rst_deb_cols",  {28'h0, cols}, 32'he);
        check("rst_deb_ready", {31'h0, bus.key_ready}, 32'h0);
        rst = 1'b0;
        step(8);
        check("rst_deb_no_key", {31'h0, bus.key_ready}, 32'h0);

        // Reset while holding a key
        do_reset();
        pressed[5] = 1'b1;
        wait_ready("rst_hold_wait", 200);
        check("rst_hold_code", {28'h0, bus.key_code}, 32'h5);
        rst = 1'b1;
        step(1);
        check("rst_hold_ready", {31'h0, bus.key_ready}, 32'h0);
        check("rst_hold_code0", {28'h0, bus.key_code}, 32'h0);
        check("rst_hold_cols",  {28'h0, cols}, 32'he);
        rst     = 1'b0;
        pressed = '0;
        step(30);
        check("rst_hold_idle", {31'h0, bus.key_ready}, 32'h0);

        // Key row1/col2 held: column parks until release is debounced
        do_reset();
        pressed[6] = 1'b1;
        wait_ready("key6_wait", 200);
        check("key6_code", {28'h0, bus.key_code}, 32'h6);
        step(20);
        check("key6_parked", {28'h0, cols}, 32'hb);
        pressed = '0;
        for (int i = 0; i < 40 && cols == 4'b1011; i++) step(1);
        check("key6_next_col", {28'h0, cols}, 32'h7);
        ack_pulse();
        check("key6_acked", {31'h0, bus.key_ready}, 32'h0);

        // Bounce: one valid sample followed by an idle sample
        raw_mode = 1'b1;
        raw_rows = 4'b1110;
        step(4);
        raw_rows = 4'b1111;
        step(40);
        check("bounce_ready", {31'h0, bus.key_ready}, 32'h0);
        changes   = 0;
        last_cols = cols;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cols != last_cols) changes++;
            last_cols = cols;
        end
        check("bounce_rotate", {31'h0, changes >= 4}, 32'h1);

        // Two rows low is not a key
        raw_rows  = 4'b1100;
        changes   = 0;
        last_cols = cols;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cols != last_cols) changes++;
            last_cols = cols;
        end
        check("multi_ready",  {31'h0, bus.key_ready}, 32'h0);
        check("multi_rotate", {31'h0, changes >= 8}, 32'h1);
        raw_mode = 1'b0;

        // Table of presses: overflow and ack behaviour
        do_reset();
        for (int v = 0; v < 5; v++) begin
            press_key(vecs[v].key);
            check("tbl_ready", {31'h0, bus.key_ready}, 32'h1);
            check("tbl_code",  {28'h0, bus.key_code}, {28'h0, vecs[v].exp_code});
            check("tbl_ovf",   {31'h0, bus.overflow}, {31'h0, vecs[v].exp_ovf});
            check("tbl_value", bus.value, exp_value(vecs[v].exp_val));
            if (vecs[v].ack) begin
                ack_pulse();
                check("tbl_ack_ready", {31'h0, bus.key_ready}, 32'h0);
                check("tbl_ack_ovf",   {31'h0, bus.overflow}, 32'h0);
            end
        end

        // Value accumulation and clear
        do_reset();
        for (int d = 1; d <= 3; d++) begin
            press_key(4'(d));
            ack_pulse();
        end
        check("value_123", bus.value, exp_value(32'h00000123));
        bus.value_clr = 1'b1;
        step(1);
        bus.value_clr = 1'b0;
        check("value_clr", bus.value, 32'h0);

        // Randomized presses against the transaction model
        do_reset();
        for (int it = 0; it < 12; it++) begin
            k = 4'($urandom_range(15));
            a = 1'($urandom_range(1));
            press_key(k);
            model_accept(k);
            compare_model("rnd");
            if (a) begin
                ack_pulse();
                m_ready = 1'b0;
                m_ovf   = 1'b0;
                compare_model("rnd_ack");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
